// File: rtl/counter_pkg.sv
// Shared constants for the BCD counter and the 4-digit display driver.
// Latency: none (types, constants and a pure helper function).
// Backpressure: none; no flow control lives here.
package counter_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int PRESCALE_W = 28;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  // Active-low seven-segment patterns, bit order {a,b,c,d,e,f,g,dp}.
  localparam logic [7:0] SEG_TABLE [0:9] = '{
    8'b00000011,  // 0
    8'b10011111,  // 1
    8'b00100101,  // 2
    8'b00001101,  // 3
    8'b10011001,  // 4
    8'b01001001,  // 5
    8'b01000001,  // 6
    8'b00011111,  // 7
    8'b00000001,  // 8
    8'b00001001   // 9
  };

  // Any nibble above 9 is not a BCD digit; it is forced to 0 on load.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? '0 : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter with inc/dec request and carry/borrow out.
// Latency: new digit one cycle after req; carry is combinational from req and the digit register.
// Backpressure: none; a request is always accepted.
module bcd_digit
  import counter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  input  logic               req,
  input  logic               up,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic               at_limit;
  logic [DIGIT_W-1:0] digit_next;

  // Limit is 9 when counting up and 0 when counting down; at the limit the
  // digit wraps and the request ripples into the next digit.
  always_comb begin
    at_limit   = up ? (digit == DIGIT_MAX) : (digit == '0);
    digit_next = digit;
    if (up) begin
      digit_next = at_limit ? '0 : digit + 1'b1;
    end else begin
      digit_next = at_limit ? DIGIT_MAX : digit - 1'b1;
    end
    carry = req & at_limit;
  end

  // Digit register: clear beats load beats a step request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_digit);
    end else if (req) begin
      digit <= digit_next;
    end
  end

endmodule

// File: rtl/bcd_counter4.sv
// Four-digit up/down BCD counter stepped by a free-running prescaler tick.
// Latency: step result, step and wrap pulses appear one cycle after the tick cycle.
// Backpressure: none; enable=0 only holds the count, the prescaler keeps running.
module bcd_counter4
  import counter_pkg::*;
#(
  parameter int unsigned TICK_DIV = 20000000
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_value,
  output logic [BCD_W-1:0] bcd,
  output logic             step,
  output logic             wrap
);

  localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIV - 1);

  logic [PRESCALE_W-1:0] prescale;
  logic                  tick;
  logic                  step_en;
  logic [NUM_DIGITS:0]   req_chain;

  assign tick    = (prescale == TICK_LAST);
  // Clear and load both take the cycle, so a coincident tick is dropped.
  assign step_en = tick & enable & ~clear & ~load;

  // Prescaler: free-running 0..TICK_DIV-1, restarted by clear but not by load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (clear || tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign req_chain[0] = step_en;

  // Units first; each digit's carry/borrow is the step request of the next.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .load       (load),
      .load_digit (load_value[i*DIGIT_W +: DIGIT_W]),
      .req        (req_chain[i]),
      .up         (up),
      .digit      (bcd[i*DIGIT_W +: DIGIT_W]),
      .carry      (req_chain[i+1])
    );
  end

  // Pulse registers: a carry out of the thousands digit is the 9999<->0000 wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      step <= step_en;
      wrap <= req_chain[NUM_DIGITS];
    end
  end

endmodule
